// File: rtl/bus_sequencer.sv
// Command-FIFO driven peripheral bus sequencer: each queued command becomes one
// timed write or read access (optional wait, setup, strobe, hold).
module bus_sequencer #(
    parameter int FIFO_DEPTH    = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_read,
    input  logic [18:0]                 cmd_addr,
    input  logic [15:0]                 cmd_data,
    input  logic [15:0]                 cmd_wait,
    output logic                        bus_enable,
    output logic [18:0]                 bus_addr,
    output logic                        bus_wr,
    output logic                        bus_rd,
    output logic [15:0]                 bus_data_out,
    input  logic [15:0]                 bus_data_in,
    output logic                        rsp_valid,
    output logic [15:0]                 rsp_data,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    // state  | meaning
    // IDLE   | bus released; pops the FIFO head when one is queued
    // WAIT   | idle gap of cmd_wait cycles before the access
    // SETUP  | enable/addr/data driven, strobes low
    // STROBE | bus_wr or bus_rd high; read data captured on the last cycle
    // HOLD   | enable/addr kept one cycle with strobes low
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 52;
    localparam logic [AW:0] DEPTH_L     = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] SETUP_LOAD  = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] STROBE_LOAD = 16'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_HOLD} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, capture;
    logic [CW-1:0] head;
    logic [15:0]   head_wait;
    logic [15:0]   timer, timer_nxt;
    logic          cur_read;
    logic [18:0]   cur_addr;
    logic [15:0]   cur_data;

    assign head      = fifo_mem[rd_ptr];
    assign head_wait = head[15:0];
    assign cmd_ready = (count < DEPTH_L);
    assign push      = cmd_valid && cmd_ready;

    // Phase timer counts down from N-1; the phase ends when it reaches zero.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (head_wait != 16'd0) begin
                        state_nxt = S_WAIT;
                        timer_nxt = head_wait - 16'd1;
                    end else begin
                        state_nxt = S_SETUP;
                        timer_nxt = SETUP_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (timer == 16'd0) begin
                    state_nxt = S_SETUP;
                    timer_nxt = SETUP_LOAD;
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            S_SETUP: begin
                if (timer == 16'd0) begin
                    state_nxt = S_STROBE;
                    timer_nxt = STROBE_LOAD;
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            S_STROBE: begin
                if (timer == 16'd0) begin
                    state_nxt = S_HOLD;
                    timer_nxt = 16'd0;
                    capture   = cur_read;
                end else begin
                    timer_nxt = timer - 16'd1;
                end
            end
            S_HOLD:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= 16'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cur_read  <= 1'b0;
            cur_addr  <= '0;
            cur_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            timer     <= 16'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            rsp_valid <= capture;
            if (capture) rsp_data <= bus_data_in;
            if (pop) begin
                rd_ptr                         <= rd_ptr + 1'b1;
                {cur_read, cur_addr, cur_data} <= head[51:16];
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset && !flush)
            fifo_mem[wr_ptr] <= {cmd_read, cmd_addr, cmd_data, cmd_wait};
    end

    // Address and write data are forced to zero off-access to keep the wired-OR bus quiet.
    assign bus_enable   = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
    assign bus_addr     = bus_enable ? cur_addr : '0;
    assign bus_data_out = (bus_enable && !cur_read) ? cur_data : '0;
    assign bus_wr       = (state == S_STROBE) && !cur_read;
    assign bus_rd       = (state == S_STROBE) && cur_read;
    assign busy         = (state != S_IDLE) || (count != '0);
    assign fifo_count   = count;
endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed scenarios plus random traffic,
// compared every cycle against a timeline model of queued accesses.
module tb_bus_sequencer;
    localparam int DEPTH  = 16;
    localparam int SETUP  = 1;
    localparam int STROBE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1, flush = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_read = 1'b0;
    logic [18:0] cmd_addr = '0;
    logic [15:0] cmd_data = '0, cmd_wait = '0;
    logic        bus_enable, bus_wr, bus_rd, rsp_valid, busy;
    logic [18:0] bus_addr;
    logic [15:0] bus_data_out, bus_data_in = '0, rsp_data;
    logic [4:0]  fifo_count;

    bus_sequencer #(.FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_wait(cmd_wait),
        .bus_enable(bus_enable), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [18:0] addr;
        logic [15:0] data;
        int          wt;
    } cmd_t;

    int   n_checks = 0, n_fail = 0;
    int   cyc = 0;
    bit   chk_on = 1'b0;
    bit   last_acc;
    cmd_t mq[$];
    cmd_t act;
    bit   act_valid = 1'b0;
    int   en_start, str_start, str_end, en_end;
    int   free_cyc = 0;
    logic [15:0] m_rsp_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit m_in_strobe(int c);
        return act_valid && c >= str_start && c <= str_end;
    endfunction

    function automatic bit m_in_wait(int c);
        return act_valid && act.wt > 0 && c < en_start && c + act.wt >= en_start;
    endfunction

    function automatic bit m_idle(int c);
        return mq.size() == 0 && !(act_valid && c <= en_end);
    endfunction

    task automatic check_outputs();
        int c = cyc;
        bit en  = act_valid && c >= en_start && c <= en_end;
        bit stb = m_in_strobe(c);
        check_eq("bus_enable", bus_enable, en);
        check_eq("bus_addr", bus_addr, en ? act.addr : 19'd0);
        check_eq("bus_data_out", bus_data_out, (en && !act.rd) ? act.data : 16'd0);
        check_eq("bus_wr", bus_wr, stb && !act.rd);
        check_eq("bus_rd", bus_rd, stb && act.rd);
        check_eq("rsp_valid", rsp_valid, act_valid && act.rd && c == en_end);
        check_eq("rsp_data", rsp_data, m_rsp_data);
        check_eq("busy", busy, (act_valid && c <= en_end) || mq.size() != 0);
        check_eq("fifo_count", fifo_count, mq.size());
        check_eq("cmd_ready", cmd_ready, mq.size() < DEPTH);
    endtask

    task automatic model_edge();
        int   c = cyc;
        bit   ready = mq.size() < DEPTH;
        bit   pop_now = mq.size() != 0 && c >= free_cyc;
        cmd_t nc;
        last_acc = 1'b0;
        if (reset) begin
            mq.delete(); act_valid = 1'b0; free_cyc = c + 1; m_rsp_data = '0;
        end else if (flush) begin
            mq.delete(); act_valid = 1'b0; free_cyc = c + 1;
        end else begin
            if (act_valid && act.rd && c == str_end) m_rsp_data = bus_data_in;
            if (pop_now) begin
                act       = mq.pop_front();
                act_valid = 1'b1;
                en_start  = c + 1 + act.wt;
                str_start = en_start + SETUP;
                str_end   = str_start + STROBE - 1;
                en_end    = str_end + 1;
                free_cyc  = en_end + 1;
            end
            if (cmd_valid && ready) begin
                nc.rd = cmd_read; nc.addr = cmd_addr; nc.data = cmd_data; nc.wt = int'(cmd_wait);
                mq.push_back(nc);
                last_acc = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        if (chk_on) check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic push_cmd(input bit rd, input logic [18:0] a, input logic [15:0] d, input logic [15:0] w);
        int i;
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_data = d; cmd_wait = w;
        for (i = 0; i < 500; i++) begin
            run_cycle();
            if (last_acc) break;
        end
        check_eq("push_accepted", last_acc, 1'b1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic drain(input int limit);
        int i;
        cmd_valid = 1'b0;
        for (i = 0; i < limit && !m_idle(cyc); i++) run_cycle();
        check_eq("drain_done", m_idle(cyc), 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        run_cycle();
        run_cycle();
        reset = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_fifo_count", fifo_count, 5'd0);
        check_eq("rst_bus_enable", bus_enable, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rsp_data", rsp_data, 16'd0);
        @(posedge clk); model_edge(); #1;

        // write, then read with fixed read data
        push_cmd(1'b0, 19'h00032, 16'hBEEF, 16'd0);
        idle(8);
        bus_data_in = 16'h1234;
        push_cmd(1'b1, 19'h00064, 16'h0000, 16'd0);
        idle(8);
        check_eq("read_rsp_data", rsp_data, 16'h1234);

        // one long access in flight, then 17 back-to-back pushes against the full FIFO
        push_cmd(1'b0, 19'h00100, 16'h0001, 16'd60);
        for (int k = 0; k < 17; k++)
            push_cmd(k[0], 19'h00200 + 19'(k), 16'hA000 + 16'(k), 16'd0);
        drain(300);

        // wait of 5 cycles
        push_cmd(1'b0, 19'h00055, 16'h5555, 16'd5);
        drain(50);

        // flush during STROBE with 3 queued
        push_cmd(1'b1, 19'h00300, 16'h0, 16'd0);
        for (int k = 0; k < 3; k++) push_cmd(1'b0, 19'h00310 + 19'(k), 16'h3100, 16'd0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 40 && !m_in_strobe(cyc); i++) run_cycle();
        check_eq("flush_in_strobe", m_in_strobe(cyc), 1'b1);
        flush = 1'b1;
        run_cycle();
        flush = 1'b0;
        check_eq("flush_busy", busy, 1'b0);
        idle(10);

        // reset during WAIT with 2 queued
        push_cmd(1'b0, 19'h00400, 16'h4000, 16'd20);
        push_cmd(1'b0, 19'h00401, 16'h4001, 16'd0);
        push_cmd(1'b1, 19'h00402, 16'h4002, 16'd0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 40 && !m_in_wait(cyc); i++) run_cycle();
        check_eq("reset_in_wait", m_in_wait(cyc), 1'b1);
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        idle(40);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cmd_valid   = ($urandom_range(0, 99) < 40);
            cmd_read    = 1'($urandom_range(0, 1));
            cmd_addr    = 19'($urandom);
            cmd_data    = 16'($urandom);
            cmd_wait    = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 7));
            bus_data_in = 16'($urandom);
            flush       = ($urandom_range(0, 99) < 2);
            reset       = ($urandom_range(0, 199) == 0);
            run_cycle();
        end
        flush = 1'b0;
        reset = 1'b0;
        drain(2000);

        // maximum wait count
        push_cmd(1'b1, 19'h7FFFF, 16'h0, 16'hFFFF);
        bus_data_in = 16'hC3A5;
        drain(70000);
        check_eq("maxwait_rsp_data", rsp_data, 16'hC3A5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, command FIFO entries (power of two).
REQ-002 SHALL have parameter SETUP_CYCLES, default 1, cycles enable/addr/data are valid before the strobe.
REQ-003 SHALL have parameter STROBE_CYCLES, default 2, cycles bus_wr or bus_rd is held high.
REQ-004 SHALL have port clk, input, 1, system clock; one clock domain only.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, discards queued commands and aborts the current access.
REQ-007 SHALL have port cmd_valid, input, 1, command offered.
REQ-008 SHALL have port cmd_ready, output, 1, FIFO can accept a command.
REQ-009 SHALL have port cmd_read, input, 1, 1 = read access, 0 = write access.
REQ-010 SHALL have port cmd_addr, input, 19, target peripheral address.
REQ-011 SHALL have port cmd_data, input, 16, write data (ignored for reads).
REQ-012 SHALL have port cmd_wait, input, 16, idle cycles inserted before the access.
REQ-013 SHALL have port bus_enable, output, 1, peripheral-bus select, active high.
REQ-014 SHALL have port bus_addr, output, 19, peripheral-bus address.
REQ-015 SHALL have port bus_wr, output, 1, write strobe, active high.
REQ-016 SHALL have port bus_rd, output, 1, read strobe, active high.
REQ-017 SHALL have port bus_data_out, output, 16, write data toward peripherals.
REQ-018 SHALL have port bus_data_in, input, 16, wired-OR read data from peripherals.
REQ-019 SHALL have port rsp_valid, output, 1, one-cycle pulse marking read data.
REQ-020 SHALL have port rsp_data, output, 16, captured read data; held until the next read.
REQ-021 SHALL have port busy, output, 1, high when the FSM is not IDLE or the FIFO is non-empty.
REQ-022 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-023 SHALL accept a command on a rising clk edge with cmd_valid & cmd_ready; cmd_ready = (fifo_count < FIFO_DEPTH), registered-state based, with no combinational path from cmd_valid.
REQ-024 SHALL, on a push and a pop in the same cycle, leave fifo_count unchanged and preserve FIFO order; read/write pointers wrap modulo FIFO_DEPTH.
REQ-025 SHALL implement FSM states IDLE, WAIT, SETUP, STROBE, HOLD.
REQ-026 SHALL, in IDLE with a non-empty FIFO, pop one entry; the next state is WAIT if cmd_wait > 0, else SETUP.
REQ-027 SHALL remain in WAIT for exactly cmd_wait cycles, then enter SETUP; cmd_wait = 0xFFFF SHALL give 65535 cycles with no overflow.
REQ-028 SHALL, in SETUP, hold bus_enable = 1, bus_addr and bus_data_out at the command values, and bus_wr = bus_rd = 0 for SETUP_CYCLES cycles.
REQ-029 SHALL, in STROBE, additionally hold bus_wr (write) or bus_rd (read) high for STROBE_CYCLES cycles; never both strobes at once.
REQ-030 SHALL, for a read, capture bus_data_in into rsp_data on the last STROBE cycle, and pulse rsp_valid for exactly one cycle, the first HOLD cycle.
REQ-031 SHALL, in HOLD, keep bus_enable and bus_addr for 1 cycle with strobes low, then return to IDLE; bus_enable SHALL be 0 in IDLE and WAIT.
REQ-032 SHALL drive bus_addr and bus_data_out to 0 whenever bus_enable = 0, so wired-OR data is not disturbed.
REQ-033 SHALL produce, with defaults and cmd_wait = 0, bus_enable high 2 cycles after the accepting edge, for 4 cycles, then the next command's bus_enable no earlier than 2 cycles later.
REQ-034 SHALL, on flush, in the following cycle: empty the FIFO (fifo_count = 0), enter IDLE, deassert all bus outputs, and suppress any pending rsp_valid; a push coincident with flush SHALL be dropped.
REQ-035 SHALL give reset priority over flush, and flush priority over push, pop and FSM advance.

Reset
REQ-036 SHALL, on clk edge with reset = 1: FSM = IDLE; FIFO empty; fifo_count = 0; cmd_ready = 1; bus_enable = bus_wr = bus_rd = 0; bus_addr = 0; bus_data_out = 0; rsp_valid = 0; rsp_data = 0; busy = 0.
REQ-037 SHALL abort any access in progress on reset mid-operation, with no further strobe cycles after the reset edge.

Verification
REQ-038 SHALL be checked with a write (addr 0x00032, data 0xBEEF, wait 0): bus_enable high cycles 2-5 after accept, bus_wr high cycles 3-4, bus_data_out = 0xBEEF, bus_rd never high.
REQ-039 SHALL be checked with a read (addr 0x00064, wait 0) while bus_data_in = 0x1234: bus_rd high for 2 cycles, one rsp_valid pulse with rsp_data = 0x1234.
REQ-040 SHALL be checked by pushing 17 commands back to back (depth 16): cmd_ready falls at count 16, the 17th command is held until a pop, and accesses are issued in push order.
REQ-041 SHALL be checked with cmd_wait = 5: exactly 5 WAIT cycles between the pop and SETUP, with bus_enable low throughout.
REQ-042 SHALL be checked by asserting flush during STROBE with 3 entries queued: next cycle strobes are low, fifo_count = 0, no rsp_valid, busy = 0.
REQ-043 SHALL be checked by asserting reset during WAIT with 2 entries queued: all outputs at reset values next cycle, and no later bus activity without new pushes.
